// File: rtl/broad_phase_scheduler.sv
// rtl/broad_phase_scheduler.sv - broad-phase AABB pair scheduler feeding the narrow-phase Collide engine
// Optional feature macro: BROAD_STATIC_SKIP_EN (skip pairs whose objects are both static)
module broad_phase_scheduler #(
   parameter int N_OBJ = 8,
   parameter int W     = 19
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [N_OBJ-1:0] static_mask,
   output logic [3:0]       rd_idx,
   input  logic [8*W-1:0]   rd_verts,
   output logic             nph_start,
   output logic [3:0]       nph_a,
   output logic [3:0]       nph_b,
   input  logic             nph_done,
   output logic             busy,
   output logic             frame_done,
   output logic [7:0]       pair_count
);

   localparam int         IW      = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;
   localparam logic [3:0] LAST    = 4'(N_OBJ - 1);
   localparam logic [4:0] LD_END  = 5'(N_OBJ);
   localparam logic [4:0] LD_LAST = 5'(N_OBJ - 1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CMP, S_ISSUE, S_WAIT, S_FIN} state_t;

   state_t     r_state;
   logic [4:0] r_ld;
   logic [3:0] r_rd_idx;
   logic [3:0] r_i;
   logic [3:0] r_j;
   logic       r_nph_start;
   logic [3:0] r_a;
   logic [3:0] r_b;
   logic       r_busy;
   logic       r_frame_done;
   logic [7:0] r_pair_count;

   // AABB table, one entry per object; fully rewritten every LOAD, so never reset
   logic signed [W-1:0] r_minx [N_OBJ];
   logic signed [W-1:0] r_maxx [N_OBJ];
   logic signed [W-1:0] r_miny [N_OBJ];
   logic signed [W-1:0] r_maxy [N_OBJ];

   logic signed [W-1:0] w_vx [4];
   logic signed [W-1:0] w_vy [4];
   logic signed [W-1:0] w_new_minx;
   logic signed [W-1:0] w_new_maxx;
   logic signed [W-1:0] w_new_miny;
   logic signed [W-1:0] w_new_maxy;
   logic                w_ld_we;
   logic [IW-1:0]       w_ld_wa;
   logic [IW-1:0]       w_ia;
   logic [IW-1:0]       w_ib;
   logic                w_overlap;
   logic                w_skip;
   logic                w_last_pair;
   logic [3:0]          w_next_i;
   logic [3:0]          w_next_j;

   function automatic logic signed [W-1:0] smin(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
      return (a < b) ? a : b;
   endfunction

   function automatic logic signed [W-1:0] smax(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
      return (a > b) ? a : b;
   endfunction

   // Split the packed hull into its four signed x and y coordinates
   always_comb begin
      for (int v = 0; v < 4; v++) begin
         w_vx[v] = rd_verts[(2*v)*W +: W];
         w_vy[v] = rd_verts[(2*v+1)*W +: W];
      end
   end

   assign w_new_minx = smin(smin(w_vx[0], w_vx[1]), smin(w_vx[2], w_vx[3]));
   assign w_new_maxx = smax(smax(w_vx[0], w_vx[1]), smax(w_vx[2], w_vx[3]));
   assign w_new_miny = smin(smin(w_vy[0], w_vy[1]), smin(w_vy[2], w_vy[3]));
   assign w_new_maxy = smax(smax(w_vy[0], w_vy[1]), smax(w_vy[2], w_vy[3]));

   // Read data lags rd_idx by one cycle, so the entry written is the previous load index
   assign w_ld_we = (r_state == S_LOAD) && (r_ld != 5'd0);
   assign w_ld_wa = IW'(r_ld - 5'd1);

   assign w_ia = r_i[IW-1:0];
   assign w_ib = r_j[IW-1:0];

   // Inclusive test: boxes that only touch on an edge still count as overlapping
   assign w_overlap = (r_minx[w_ia] <= r_maxx[w_ib]) && (r_minx[w_ib] <= r_maxx[w_ia]) &&
                      (r_miny[w_ia] <= r_maxy[w_ib]) && (r_miny[w_ib] <= r_maxy[w_ia]);

`ifdef BROAD_STATIC_SKIP_EN
   assign w_skip = static_mask[w_ia] & static_mask[w_ib];
`else
   logic w_unused_mask;
   assign w_unused_mask = ^static_mask;
   assign w_skip        = 1'b0;
`endif

   // Lexicographic pair walk: (i,j) -> (i,j+1), or (i+1,i+2) once j hits the last object
   assign w_last_pair = (r_j == LAST) && (4'(r_i + 4'd1) == LAST);
   assign w_next_i    = (r_j == LAST) ? 4'(r_i + 4'd1) : r_i;
   assign w_next_j    = (r_j == LAST) ? 4'(r_i + 4'd2) : 4'(r_j + 4'd1);

   // Capture the reduced AABB of the object whose vertices are on rd_verts this cycle
   always_ff @(posedge clk) begin
      if (w_ld_we) begin
         r_minx[w_ld_wa] <= w_new_minx;
         r_maxx[w_ld_wa] <= w_new_maxx;
         r_miny[w_ld_wa] <= w_new_miny;
         r_maxy[w_ld_wa] <= w_new_maxy;
      end
   end

   // Frame sequencer with registered outputs: load hulls, scan pairs, issue jobs, report
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_ld         <= 5'd0;
         r_rd_idx     <= 4'd0;
         r_i          <= 4'd0;
         r_j          <= 4'd0;
         r_nph_start  <= 1'b0;
         r_a          <= 4'd0;
         r_b          <= 4'd0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
         r_pair_count <= 8'd0;
      end else begin
         r_nph_start  <= 1'b0;
         r_frame_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_pair_count <= 8'd0;
                  r_ld         <= 5'd0;
                  r_rd_idx     <= 4'd0;
                  r_busy       <= 1'b1;
                  r_state      <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (r_ld == LD_END) begin
                  r_i     <= 4'd0;
                  r_j     <= 4'd1;
                  r_state <= S_CMP;
               end else begin
                  r_ld <= r_ld + 5'd1;
                  if (r_ld < LD_LAST) begin
                     r_rd_idx <= r_rd_idx + 4'd1;
                  end
               end
            end
            S_CMP: begin
               if (w_overlap && !w_skip) begin
                  r_nph_start <= 1'b1;
                  r_a         <= r_i;
                  r_b         <= r_j;
                  r_state     <= S_ISSUE;
               end else if (w_last_pair) begin
                  r_state <= S_FIN;
               end else begin
                  r_i     <= w_next_i;
                  r_j     <= w_next_j;
                  r_state <= S_CMP;
               end
            end
            S_ISSUE: begin
               r_pair_count <= r_pair_count + 8'd1;
               r_state      <= S_WAIT;
            end
            S_WAIT: begin
               if (nph_done) begin
                  if (w_last_pair) begin
                     r_state <= S_FIN;
                  end else begin
                     r_i     <= w_next_i;
                     r_j     <= w_next_j;
                     r_state <= S_CMP;
                  end
               end
            end
            S_FIN: begin
               r_frame_done <= 1'b1;
               r_busy       <= 1'b0;
               r_state      <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign rd_idx     = r_rd_idx;
   assign nph_start  = r_nph_start;
   assign nph_a      = r_a;
   assign nph_b      = r_b;
   assign busy       = r_busy;
   assign frame_done = r_frame_done;
   assign pair_count = r_pair_count;

endmodule

// File: tb/tb_broad_phase_scheduler.sv
// tb/tb_broad_phase_scheduler.sv - scoreboard bench for broad_phase_scheduler (N_OBJ=2 and N_OBJ=16 instances)
`timescale 1ns/1ps
module tb_broad_phase_scheduler;

   localparam int W = 19;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        start;
   logic        nph_done;
   logic        sel;
   logic [15:0] static_mask;

   logic [8*W-1:0] tbl [16];

   logic [3:0]     s2_rd_idx, s2_a, s2_b;
   logic [8*W-1:0] s2_verts;
   logic           s2_ns, s2_busy, s2_fd;
   logic [7:0]     s2_pc;

   logic [3:0]     s16_rd_idx, s16_a, s16_b;
   logic [8*W-1:0] s16_verts;
   logic           s16_ns, s16_busy, s16_fd;
   logic [7:0]     s16_pc;

   logic [3:0] o_rd_idx, o_a, o_b;
   logic       o_ns, o_busy, o_fd;
   logic [7:0] o_pc;

   int errors = 0;
   int checks = 0;
   logic [7:0] exp_q [$];

   broad_phase_scheduler #(.N_OBJ(2), .W(W)) u_dut2 (
      .clk(clk), .rst(rst), .start(start & ~sel), .static_mask(static_mask[1:0]),
      .rd_idx(s2_rd_idx), .rd_verts(s2_verts), .nph_start(s2_ns), .nph_a(s2_a), .nph_b(s2_b),
      .nph_done(nph_done & ~sel), .busy(s2_busy), .frame_done(s2_fd), .pair_count(s2_pc)
   );

   broad_phase_scheduler #(.N_OBJ(16), .W(W)) u_dut16 (
      .clk(clk), .rst(rst), .start(start & sel), .static_mask(static_mask),
      .rd_idx(s16_rd_idx), .rd_verts(s16_verts), .nph_start(s16_ns), .nph_a(s16_a), .nph_b(s16_b),
      .nph_done(nph_done & sel), .busy(s16_busy), .frame_done(s16_fd), .pair_count(s16_pc)
   );

   // Object table with one cycle of read latency
   always @(posedge clk) begin
      s2_verts  <= tbl[s2_rd_idx];
      s16_verts <= tbl[s16_rd_idx];
   end

   assign o_rd_idx = sel ? s16_rd_idx : s2_rd_idx;
   assign o_a      = sel ? s16_a      : s2_a;
   assign o_b      = sel ? s16_b      : s2_b;
   assign o_ns     = sel ? s16_ns     : s2_ns;
   assign o_busy   = sel ? s16_busy   : s2_busy;
   assign o_fd     = sel ? s16_fd     : s2_fd;
   assign o_pc     = sel ? s16_pc     : s2_pc;

   task automatic set_box(input int k, input int x0, input int x1, input int y0, input int y1, input int rot);
      int vx [4];
      int vy [4];
      int c;
      logic [8*W-1:0] p;
      logic signed [W-1:0] cx, cy;
      vx[0] = x1; vy[0] = y0;
      vx[1] = x0; vy[1] = y0;
      vx[2] = x0; vy[2] = y1;
      vx[3] = x1; vy[3] = y1;
      p = '0;
      for (int v = 0; v < 4; v++) begin
         c  = (v + rot) % 4;
         cx = W'(vx[c] * 256);
         cy = W'(vy[c] * 256);
         p[(2*v)*W +: W]   = cx;
         p[(2*v+1)*W +: W] = cy;
      end
      tbl[k] = p;
   endtask

   task automatic fill_spread();
      for (int k = 0; k < 16; k++) set_box(k, 100 + k*60, 120 + k*60, 0, 10, k % 4);
   endtask

   task automatic run_frame(input int lat, input bit spam, output int issues, output int fd_cyc);
      int cnt;
      bit done;
      bit fd_busy;
      logic [7:0] e, held;
      issues = 0; fd_cyc = -1; cnt = 0; done = 0; fd_busy = 1'b1; held = 8'h00;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      checks++;
      if (o_busy !== 1'b1 || o_rd_idx !== 4'd0) begin
         errors++;
         $display("FAIL start_latency: busy=%b rd_idx=%0d, want busy=1 rd_idx=0", o_busy, o_rd_idx);
      end
      for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
         if (cyc > 0) @(negedge clk);
         nph_done = 1'b0;
         start    = spam && (o_busy === 1'b1) && (cyc % 29 == 7);
         if (o_ns === 1'b1) begin
            issues++;
            held = {o_a, o_b};
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_issue: got pair (%0d,%0d), want none", o_a, o_b);
            end else begin
               e = exp_q.pop_front();
               if ({o_a, o_b} !== e) begin
                  errors++;
                  $display("FAIL issue_order: got (%0d,%0d), want (%0d,%0d)", o_a, o_b, e[7:4], e[3:0]);
               end
            end
            cnt = lat;
         end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               checks++;
               if ({o_a, o_b} !== held) begin
                  errors++;
                  $display("FAIL pair_hold: got (%0d,%0d), want (%0d,%0d)", o_a, o_b, held[7:4], held[3:0]);
               end
               nph_done = 1'b1;
            end
         end
         if (o_fd === 1'b1) begin
            done = 1'b1; fd_cyc = cyc; fd_busy = o_busy;
         end
      end
      nph_done = 1'b0; start = 1'b0;
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL frame_timeout: no frame_done within 3000 cycles");
      end else if (fd_busy !== 1'b0) begin
         errors++;
         $display("FAIL busy_at_done: busy=%b, want 0", fd_busy);
      end
      @(negedge clk);
      checks++;
      if (o_fd !== 1'b0) begin
         errors++;
         $display("FAIL done_pulse: frame_done=%b one cycle later, want 0", o_fd);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL missing_issues: %0d expected pairs never issued, want 0", exp_q.size());
      end
      exp_q.delete();
   endtask

   task automatic test_reset();
      rst = 1'b0; start = 1'b0; nph_done = 1'b0; sel = 1'b0; static_mask = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({s2_rd_idx, s2_ns, s2_a, s2_b, s2_busy, s2_fd, s2_pc} !== 23'd0) begin
         errors++;
         $display("FAIL reset_n2: outputs=%h, want 0", {s2_rd_idx, s2_ns, s2_a, s2_b, s2_busy, s2_fd, s2_pc});
      end
      checks++;
      if ({s16_rd_idx, s16_ns, s16_a, s16_b, s16_busy, s16_fd, s16_pc} !== 23'd0) begin
         errors++;
         $display("FAIL reset_n16: outputs=%h, want 0", {s16_rd_idx, s16_ns, s16_a, s16_b, s16_busy, s16_fd, s16_pc});
      end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic check_frame(input string name, input int issues, input int want_issues, input int want_pc);
      checks++;
      if (issues != want_issues) begin
         errors++;
         $display("FAIL %s_issues: got %0d, want %0d", name, issues, want_issues);
      end
      checks++;
      if (o_pc !== 8'(want_pc)) begin
         errors++;
         $display("FAIL %s_pair_count: got %0d, want %0d", name, o_pc, want_pc);
      end
   endtask

   task automatic test_single_overlap();
      int iss, fdc;
      sel = 1'b0; static_mask = '0;
      set_box(0, 50, 150, 50, 150, 0);
      set_box(1, 100, 200, 0, 100, 1);
      exp_q.push_back({4'd0, 4'd1});
      run_frame(10, 1'b0, iss, fdc);
      check_frame("single", iss, 1, 1);
      // LOAD 0..2, CMP 3, ISSUE 4, done at 14, FIN 15, frame_done 16
      checks++;
      if (fdc != 16) begin
         errors++;
         $display("FAIL single_latency: frame_done at cycle %0d, want 16", fdc);
      end
   endtask

   task automatic test_touching();
      int iss, fdc;
      sel = 1'b0; static_mask = '0;
      set_box(0, 50, 150, 50, 150, 0);
      set_box(1, 150, 250, 0, 100, 2);
      exp_q.push_back({4'd0, 4'd1});
      run_frame(4, 1'b0, iss, fdc);
      check_frame("touch", iss, 1, 1);
      set_box(1, 151, 251, 0, 100, 3);
      run_frame(4, 1'b0, iss, fdc);
      check_frame("apart", iss, 0, 0);
      checks++;
      if (fdc != 5) begin
         errors++;
         $display("FAIL apart_latency: frame_done at cycle %0d, want 5", fdc);
      end
   endtask

   task automatic test_static_skip();
      int iss, fdc, want;
      sel = 1'b0; static_mask = 16'h0003;
      set_box(0, 50, 150, 50, 150, 1);
      set_box(1, 100, 200, 0, 100, 0);
`ifdef BROAD_STATIC_SKIP_EN
      want = 0;
`else
      want = 1;
      exp_q.push_back({4'd0, 4'd1});
`endif
      run_frame(6, 1'b0, iss, fdc);
      check_frame("static", iss, want, want);
      static_mask = '0;
   endtask

   task automatic test_negative();
      int iss, fdc;
      sel = 1'b1; static_mask = '0;
      fill_spread();
      set_box(2, -20, -5, 0, 10, 1);
      set_box(3, -10, 30, 0, 10, 2);
      exp_q.push_back({4'd2, 4'd3});
      run_frame(5, 1'b0, iss, fdc);
      check_frame("negative", iss, 1, 1);
   endtask

   task automatic test_all_overlap();
      int iss, fdc;
      sel = 1'b1; static_mask = '0;
      for (int k = 0; k < 16; k++) set_box(k, 0, 100, 0, 100, k % 4);
      for (int i = 0; i < 16; i++)
         for (int j = i + 1; j < 16; j++)
            exp_q.push_back({4'(i), 4'(j)});
      run_frame(3, 1'b1, iss, fdc);
      check_frame("all", iss, 120, 120);
   endtask

   task automatic test_reset_mid_wait();
      int iss, fdc;
      bit seen;
      sel = 1'b1; static_mask = '0;
      for (int k = 0; k < 16; k++) set_box(k, 0, 100, 0, 100, 0);
      seen = 1'b0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int c = 0; c < 100 && !seen; c++) begin
         @(negedge clk);
         if (o_ns === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen || o_a !== 4'd0 || o_b !== 4'd1) begin
         errors++;
         $display("FAIL abort_issue: seen=%b pair (%0d,%0d), want (0,1)", seen, o_a, o_b);
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if ({o_rd_idx, o_ns, o_a, o_b, o_busy, o_fd, o_pc} !== 23'd0) begin
         errors++;
         $display("FAIL async_reset: outputs=%h, want 0", {o_rd_idx, o_ns, o_a, o_b, o_busy, o_fd, o_pc});
      end
      seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (o_fd !== 1'b0) seen = 1'b1;
      end
      rst = 1'b1;
      repeat (2) begin
         @(negedge clk);
         if (o_fd !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL abort_no_done: frame_done seen after reset, want none");
      end
      fill_spread();
      run_frame(2, 1'b0, iss, fdc);
      check_frame("after_abort", iss, 0, 0);
      // 17 load cycles + 120 pair cycles + FIN, frame_done one cycle later
      checks++;
      if (fdc != 138) begin
         errors++;
         $display("FAIL after_abort_latency: frame_done at cycle %0d, want 138", fdc);
      end
   endtask

   initial begin
      test_reset();
      test_single_overlap();
      test_touching();
      test_static_skip();
      test_negative();
      test_all_overlap();
      test_reset_mid_wait();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
